// File: rtl/magnetron_ctrl.sv
// Magnetron on/off controller: synchronised front-panel inputs, IDLE/COOKING/PAUSED
// session FSM and a windowed PWM of the magnetron enable by power level.
module magnetron_ctrl #(
  parameter int LEVELS      = 10,
  parameter int SLOT_CYCLES = 10,
  parameter int LW          = $clog2(LEVELS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          startn,
  input  logic          stopn,
  input  logic          clearn,
  input  logic          door_closed,
  input  logic          timer_done,
  input  logic [LW-1:0] power_level,
  output logic          mag_on,
  output logic          cooking,
  output logic          paused,
  output logic [1:0]    state,
  output logic          done_pulse
);

  localparam int WINDOW = LEVELS * SLOT_CYCLES;
  localparam int CW     = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COOKING = 2'b01,
    PAUSED  = 2'b10
  } state_e;

  // Button vectors are ordered {clear, stop, start}; level vectors {timer, door}.
  logic [2:0]    btn_s1_q, btn_s2_q, btn_prev_q;
  logic [1:0]    lvl_s1_q, lvl_s2_q;
  state_e        state_q, state_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lvl_q, lvl_d;

  logic          start_press, stop_press, clear_press;
  logic          door_s, timer_s;
  logic [LW-1:0] clamp_lvl;
  logic [CW-1:0] on_cycles;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1_q   <= '1;
      btn_s2_q   <= '1;
      btn_prev_q <= '1;
      lvl_s1_q   <= '0;
      lvl_s2_q   <= '0;
      state_q    <= IDLE;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      lvl_q      <= '0;
    end else begin
      btn_s1_q   <= {clearn, stopn, startn};
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
      lvl_s1_q   <= {timer_done, door_closed};
      lvl_s2_q   <= lvl_s1_q;
      state_q    <= state_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      lvl_q      <= lvl_d;
    end
  end

  // A press is the falling edge of the synchronised button: one per low transition.
  assign start_press = btn_prev_q[0] & ~btn_s2_q[0];
  assign stop_press  = btn_prev_q[1] & ~btn_s2_q[1];
  assign clear_press = btn_prev_q[2] & ~btn_s2_q[2];
  assign door_s      = lvl_s2_q[0];
  assign timer_s     = lvl_s2_q[1];

  assign clamp_lvl = (power_level > LW'(LEVELS)) ? LW'(LEVELS) : power_level;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_press && !stop_press && door_s && !timer_s && (power_level != '0))
          state_d = COOKING;
      end
      COOKING: begin
        if (clear_press) begin
          state_d = IDLE;
        end else if (timer_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (stop_press || !door_s) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (clear_press) begin
          state_d = IDLE;
        end else if (timer_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (stop_press) begin
          state_d = IDLE;
        end else if (start_press && door_s) begin
          state_d = COOKING;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // PWM window restarts on every entry into COOKING; level reloads on entry and wrap.
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    if (state_d == COOKING) begin
      if (state_q != COOKING || cnt_q == CW'(WINDOW - 1)) begin
        lvl_d = clamp_lvl;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign on_cycles  = CW'(lvl_q) * CW'(SLOT_CYCLES);
  assign mag_on     = (state_q == COOKING) && (cnt_q < on_cycles);
  assign cooking    = (state_q == COOKING);
  assign paused     = (state_q == PAUSED);
  assign state      = state_q;
  assign done_pulse = done_q;

endmodule

// File: tb/tb_magnetron_ctrl.sv
// Directed bench for magnetron_ctrl with LEVELS=10, SLOT_CYCLES=2 (WINDOW=20).
module tb_magnetron_ctrl;

  logic       clk = 1'b0;
  logic       reset, startn, stopn, clearn, door_closed, timer_done;
  logic [3:0] power_level;
  logic       mag_on, cooking, paused, done_pulse;
  logic [1:0] state;

  int cmp_count = 0;
  int err_count = 0;

  // Observed vector: {state, cooking, paused, mag_on, done_pulse}
  localparam logic [5:0] IDLE_O   = 6'b00_0_0_0_0;
  localparam logic [5:0] COOK_ON  = 6'b01_1_0_1_0;
  localparam logic [5:0] COOK_OFF = 6'b01_1_0_0_0;
  localparam logic [5:0] PAUSE_O  = 6'b10_0_1_0_0;
  localparam logic [5:0] DONE_O   = 6'b00_0_0_0_1;

  magnetron_ctrl #(.LEVELS(10), .SLOT_CYCLES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .startn      (startn),
    .stopn       (stopn),
    .clearn      (clearn),
    .door_closed (door_closed),
    .timer_done  (timer_done),
    .power_level (power_level),
    .mag_on      (mag_on),
    .cooking     (cooking),
    .paused      (paused),
    .state       (state),
    .done_pulse  (done_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] obs();
    return {state, cooking, paused, mag_on, done_pulse};
  endfunction

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Buttons held low for exactly one cycle; returns right after the state update edge.
  task automatic pulse(input logic s, input logic p, input logic c);
    startn = ~s;
    stopn  = ~p;
    clearn = ~c;
    tick();
    startn = 1'b1;
    stopn  = 1'b1;
    clearn = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    reset = 1'b1; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b0; timer_done = 1'b0; power_level = 4'd0;
    tick();
    if (obs() !== IDLE_O) begin
      err_count++;
      $display("FAIL reset: got %b expected %b", obs(), IDLE_O);
    end
    cmp_count++;
    reset = 1'b0;
    door_closed = 1'b1;
    tick(3);
    if (obs() !== IDLE_O) begin
      err_count++;
      $display("FAIL reset_idle: got %b expected %b", obs(), IDLE_O);
    end
    cmp_count++;
  endtask

  task automatic test_pwm();
    logic [5:0] exp;
    power_level = 4'd5;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      exp = ((i % 20) < 10) ? COOK_ON : COOK_OFF;
      if (obs() !== exp) begin
        err_count++;
        $display("FAIL pwm cycle %0d: got %b expected %b", i, obs(), exp);
      end
      cmp_count++;
      tick();
    end
    pulse(1'b0, 1'b0, 1'b1);
    if (obs() !== IDLE_O) begin
      err_count++;
      $display("FAIL pwm_clear: got %b expected %b", obs(), IDLE_O);
    end
    cmp_count++;
  endtask

  task automatic test_level_change();
    logic [5:0] exp;
    power_level = 4'd5;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (i < 20) exp = (i < 10) ? COOK_ON : COOK_OFF;
      else        exp = ((i - 20) < 4) ? COOK_ON : COOK_OFF;
      if (obs() !== exp) begin
        err_count++;
        $display("FAIL level_change cycle %0d: got %b expected %b", i, obs(), exp);
      end
      cmp_count++;
      if (i == 3) power_level = 4'd2;
      tick();
    end
    pulse(1'b0, 1'b0, 1'b1);
    power_level = 4'd5;
  endtask

  task automatic test_door_gate();
    door_closed = 1'b0;
    tick(3);
    pulse(1'b1, 1'b0, 1'b0);
    if (obs() !== IDLE_O) begin
      err_count++;
      $display("FAIL door_open_start: got %b expected %b", obs(), IDLE_O);
    end
    cmp_count++;
    door_closed = 1'b1;
    tick(4);
    if (obs() !== IDLE_O) begin
      err_count++;
      $display("FAIL door_close_no_press: got %b expected %b", obs(), IDLE_O);
    end
    cmp_count++;
    pulse(1'b1, 1'b0, 1'b0);
    if (obs() !== COOK_ON) begin
      err_count++;
      $display("FAIL door_closed_start: got %b expected %b", obs(), COOK_ON);
    end
    cmp_count++;
    pulse(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_pause_resume();
    logic [5:0] exp;
    pulse(1'b1, 1'b0, 1'b0);
    tick(5);
    door_closed = 1'b0;
    tick(2);
    if (obs() !== COOK_ON) begin
      err_count++;
      $display("FAIL door_open_latency: got %b expected %b", obs(), COOK_ON);
    end
    cmp_count++;
    tick();
    if (obs() !== PAUSE_O) begin
      err_count++;
      $display("FAIL door_open_pause: got %b expected %b", obs(), PAUSE_O);
    end
    cmp_count++;
    door_closed = 1'b1;
    tick(4);
    if (obs() !== PAUSE_O) begin
      err_count++;
      $display("FAIL door_close_stays_paused: got %b expected %b", obs(), PAUSE_O);
    end
    cmp_count++;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      exp = (i < 10) ? COOK_ON : COOK_OFF;
      if (obs() !== exp) begin
        err_count++;
        $display("FAIL resume_pwm cycle %0d: got %b expected %b", i, obs(), exp);
      end
      cmp_count++;
      tick();
    end
    pulse(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_stop_priority();
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    if (obs() !== PAUSE_O) begin
      err_count++;
      $display("FAIL stop_pause: got %b expected %b", obs(), PAUSE_O);
    end
    cmp_count++;
    pulse(1'b1, 1'b1, 1'b0);
    if (obs() !== IDLE_O) begin
      err_count++;
      $display("FAIL start_stop_same_cycle: got %b expected %b", obs(), IDLE_O);
    end
    cmp_count++;
    pulse(1'b1, 1'b0, 1'b0);
    if (obs() !== COOK_ON) begin
      err_count++;
      $display("FAIL restart: got %b expected %b", obs(), COOK_ON);
    end
    cmp_count++;
    pulse(1'b0, 1'b1, 1'b0);
    if (obs() !== PAUSE_O) begin
      err_count++;
      $display("FAIL first_stop: got %b expected %b", obs(), PAUSE_O);
    end
    cmp_count++;
    pulse(1'b0, 1'b1, 1'b0);
    if (obs() !== IDLE_O) begin
      err_count++;
      $display("FAIL second_stop: got %b expected %b", obs(), IDLE_O);
    end
    cmp_count++;
  endtask

  task automatic test_timer_done();
    pulse(1'b1, 1'b0, 1'b0);
    timer_done = 1'b1;
    tick(2);
    if (obs() !== COOK_ON) begin
      err_count++;
      $display("FAIL timer_latency: got %b expected %b", obs(), COOK_ON);
    end
    cmp_count++;
    tick();
    if (obs() !== DONE_O) begin
      err_count++;
      $display("FAIL timer_done_pulse: got %b expected %b", obs(), DONE_O);
    end
    cmp_count++;
    tick();
    if (obs() !== IDLE_O) begin
      err_count++;
      $display("FAIL done_pulse_width: got %b expected %b", obs(), IDLE_O);
    end
    cmp_count++;
    pulse(1'b1, 1'b0, 1'b0);
    if (obs() !== IDLE_O) begin
      err_count++;
      $display("FAIL start_while_timer_done: got %b expected %b", obs(), IDLE_O);
    end
    cmp_count++;
    timer_done = 1'b0;
    tick(3);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    timer_done = 1'b1;
    tick(3);
    if (obs() !== DONE_O) begin
      err_count++;
      $display("FAIL paused_timer_done: got %b expected %b", obs(), DONE_O);
    end
    cmp_count++;
    timer_done = 1'b0;
    tick(3);
  endtask

  task automatic test_clamp_reset();
    power_level = 4'd0;
    pulse(1'b1, 1'b0, 1'b0);
    if (obs() !== IDLE_O) begin
      err_count++;
      $display("FAIL zero_level_start: got %b expected %b", obs(), IDLE_O);
    end
    cmp_count++;
    power_level = 4'd15;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 45; i++) begin
      if (obs() !== COOK_ON) begin
        err_count++;
        $display("FAIL clamp cycle %0d: got %b expected %b", i, obs(), COOK_ON);
      end
      cmp_count++;
      tick();
    end
    reset = 1'b1;
    tick();
    if (obs() !== IDLE_O) begin
      err_count++;
      $display("FAIL reset_mid_cook: got %b expected %b", obs(), IDLE_O);
    end
    cmp_count++;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_pwm();
    test_level_change();
    test_door_gate();
    test_pause_resume();
    test_stop_priority();
    test_timer_done();
    test_clamp_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
